// File: rtl/sisd_col_pkg.sv
// Shared definitions for the column-serial to row-parallel path: default sizes,
// collector state encoding and the assembled row type.
package sisd_col_pkg;

   localparam int DEF_DATA_W   = 8;
   localparam int DEF_NUM_COLS = 4;
   localparam int DEF_COL_W    = $clog2(DEF_NUM_COLS);

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } col_state_t;

   typedef logic [DEF_NUM_COLS*DEF_DATA_W-1:0] row_t;

endpackage

// File: rtl/col_index_counter.sv
// Wrapping column index with synchronous clear; wrap pulses on the increment
// that leaves the last column.
module col_index_counter #(
   parameter int COL_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   output logic [COL_W-1:0] count,
   output logic             wrap
);

   logic [COL_W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count_reg <= '0;
      end else if (en) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count = count_reg;
   assign wrap  = en && (count_reg == {COL_W{1'b1}});

endmodule

// File: rtl/column_collector.sv
// Collects DATA_W elements into a NUM_COLS-wide row and hands it downstream.
// Optional partial-row flush is enabled with the COLLECTOR_FLUSH_EN macro.
module column_collector
   import sisd_col_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_COLS = DEF_NUM_COLS,
   parameter int COL_W    = $clog2(NUM_COLS)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       in_ready,
   output logic [COL_W-1:0]           col_idx,
   output logic                       out_valid,
   output logic [NUM_COLS*DATA_W-1:0] out_row,
`ifdef COLLECTOR_FLUSH_EN
   input  logic                       flush,
`endif
   input  logic                       out_ready
);

   col_state_t        state_reg;
   logic              out_valid_reg;
   logic [DATA_W-1:0] slot_reg [NUM_COLS];
   logic              accept;
   logic              wrap;
   logic              flush_go;

   // In FULL the input only moves when the row drains in the same cycle.
   assign in_ready = (state_reg == FILL) || out_ready;
   assign accept   = in_valid && in_ready;

`ifdef COLLECTOR_FLUSH_EN
   assign flush_go = flush && (state_reg == FILL) && ((col_idx != '0) || accept);
`else
   assign flush_go = 1'b0;
`endif

   col_index_counter #(
      .COL_W (COL_W)
   ) u_col_index_counter (
      .clk   (clk),
      .reset (reset),
      .en    (accept),
      .clr   (flush_go),
      .count (col_idx),
      .wrap  (wrap)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= FILL;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            FILL: begin
               if (wrap || flush_go) begin
                  state_reg     <= FULL;
                  out_valid_reg <= 1'b1;
               end
            end
            FULL: begin
               if (out_ready) begin
                  state_reg     <= FILL;
                  out_valid_reg <= 1'b0;
               end
            end
            default: begin
               state_reg     <= FILL;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   // Flush zeroes every slot at or beyond the index not written this cycle.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_COLS; c++) begin
         if (reset) begin
            slot_reg[c] <= '0;
         end else if (accept && (col_idx == COL_W'(c))) begin
            slot_reg[c] <= in_data;
         end else if (flush_go && (COL_W'(c) >= col_idx)) begin
            slot_reg[c] <= '0;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_row
         assign out_row[gi*DATA_W +: DATA_W] = slot_reg[gi];
      end
   endgenerate

   assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_column_collector.sv
// Directed and randomized checks of column_collector against a queue-based row model.
module tb_column_collector;

   localparam int DATA_W   = 8;
   localparam int NUM_COLS = 4;
   localparam int COL_W    = 2;

   logic                       clk = 1'b0;
   logic                       reset = 1'b1;
   logic                       in_valid = 1'b0;
   logic [DATA_W-1:0]          in_data = '0;
   logic                       in_ready;
   logic [COL_W-1:0]           col_idx;
   logic                       out_valid;
   logic [NUM_COLS*DATA_W-1:0] out_row;
   logic                       out_ready = 1'b0;
   logic                       flush = 1'b0;

   int passed = 0;
   int total  = 0;
   bit chk_en = 1'b0;

   // Behavioural model: elements queue up until a row's worth exists.
   logic [DATA_W-1:0]          part [$];
   bit                         mfull = 1'b0;
   logic [NUM_COLS*DATA_W-1:0] mrow = '0;
   int                         rows_out = 0;

   column_collector dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .col_idx   (col_idx),
      .out_valid (out_valid),
      .out_row   (out_row),
`ifdef COLLECTOR_FLUSH_EN
      .flush     (flush),
`endif
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else
         passed++;
   endtask

   task automatic model_step();
      bit was_full, rdy, acc, fl;
      if (reset) begin
         part.delete();
         mfull = 1'b0;
         mrow  = '0;
         return;
      end
      was_full = mfull;
      rdy = !mfull || out_ready;
      acc = in_valid && rdy;
      if (mfull && out_ready) begin
         mfull = 1'b0;
         rows_out++;
         $display("row %0d consumed: %h", rows_out, mrow);
      end
      fl = 1'b0;
`ifdef COLLECTOR_FLUSH_EN
      fl = flush && !was_full && ((part.size() > 0) || acc);
`endif
      if (acc) part.push_back(in_data);
      if (part.size() == NUM_COLS || fl) begin
         while (part.size() < NUM_COLS) part.push_back('0);
         for (int c = 0; c < NUM_COLS; c++) mrow[c*DATA_W +: DATA_W] = part[c];
         part.delete();
         mfull = 1'b1;
      end
   endtask

   task automatic cyc(input bit v, input logic [DATA_W-1:0] d, input bit r);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      @(posedge clk);
      model_step();
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_out_valid", 64'(out_valid), 64'(mfull));
         chk("m_in_ready", 64'(in_ready), 64'(!mfull || out_ready));
         chk("m_col_idx", 64'(col_idx), 64'(part.size()));
         if (mfull) chk("m_out_row", 64'(out_row), 64'(mrow));
      end
   end

   initial begin
      int rows;
      logic [NUM_COLS*DATA_W-1:0] held;

      reset = 1'b1;
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      reset = 1'b0;
      chk("rst_col_idx", 64'(col_idx), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_row", 64'(out_row), 64'd0);
      chk_en = 1'b1;

      // Fill one row under backpressure.
      cyc(1, 8'h11, 0);
      cyc(1, 8'h22, 0);
      cyc(1, 8'h33, 0);
      chk("t1_not_yet_valid", 64'(out_valid), 64'd0);
      cyc(1, 8'h44, 0);
      chk("t1_out_valid", 64'(out_valid), 64'd1);
      chk("t1_out_row", 64'(out_row), 64'h44332211);
      chk("t1_in_ready", 64'(in_ready), 64'd0);

      // Drain and restart in the same cycle.
      cyc(1, 8'hAA, 1);
      chk("t2_out_valid", 64'(out_valid), 64'd0);
      chk("t2_col_idx", 64'(col_idx), 64'd1);
      cyc(1, 8'hBB, 0);
      cyc(1, 8'hCC, 0);
      cyc(1, 8'hDD, 0);
      chk("t2_out_row", 64'(out_row), 64'hDDCCBBAA);
      cyc(0, 8'h5A, 1);
      chk("t2_drain_idle_col", 64'(col_idx), 64'd0);
      chk("t2_drain_idle_valid", 64'(out_valid), 64'd0);

      // Streaming at full rate.
      rows = 0;
      for (int k = 1; k <= 16; k++) begin
         cyc(1, 8'($urandom), 1);
         chk("t3_in_ready", 64'(in_ready), 64'd1);
         chk("t3_col_idx", 64'(col_idx), 64'(k % NUM_COLS));
         if (out_valid) rows++;
      end
      chk("t3_rows", 64'(rows), 64'd4);
      cyc(0, 0, 1);

      // Reset in the middle of a row.
      cyc(1, 8'h77, 0);
      cyc(1, 8'h88, 0);
      reset = 1'b1;
      cyc(0, 0, 0);
      reset = 1'b0;
      chk("t4_col_idx", 64'(col_idx), 64'd0);
      chk("t4_out_valid", 64'(out_valid), 64'd0);
      for (int k = 1; k <= 4; k++) cyc(1, 8'(k), 0);
      chk("t4_out_row", 64'(out_row), 64'h04030201);

      // Long backpressure in FULL.
      held = out_row;
      for (int k = 0; k < 10; k++) begin
         cyc(1, 8'($urandom), 0);
         chk("t5_row_stable", 64'(out_row), 64'(held));
         chk("t5_col_idx", 64'(col_idx), 64'd0);
         chk("t5_in_ready", 64'(in_ready), 64'd0);
      end
      cyc(0, 0, 1);

`ifdef COLLECTOR_FLUSH_EN
      cyc(1, 8'h55, 0);
      cyc(1, 8'h66, 0);
      flush = 1'b1;
      cyc(0, 0, 0);
      flush = 1'b0;
      chk("t6_out_valid", 64'(out_valid), 64'd1);
      chk("t6_out_row", 64'(out_row), 64'h00006655);
      chk("t6_col_idx", 64'(col_idx), 64'd0);
      cyc(0, 0, 1);
`endif

      // Randomized traffic against the model.
      for (int k = 0; k < 600; k++) begin
         reset = ($urandom_range(0, 59) == 0);
`ifdef COLLECTOR_FLUSH_EN
         flush = ($urandom_range(0, 7) == 0);
`endif
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0));
      end
      reset = 1'b0;
      flush = 1'b0;
      cyc(0, 0, 0);
      @(negedge clk);
      chk_en = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
